seg_scan_ctrl: RTL

Memory-mapped 8-digit seven-segment display controller that sits directly downstream of the pipeline's MEM/WB stage. It captures the 32-bit word the CPU stores to the display address, and it time-multiplexes that word as 8 hex digits onto the board's common-anode display. Optional leading-zero blanking is supported, and the controller emits a frame-done pulse for debug and test.

---
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit common-anode seven-segment scanner fed by CPU stores to a
// memory-mapped display register, with optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DIGITS    = 8,
    parameter logic [5:0]  DISP_ADDR = 6'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        blank_en,
    output logic [31:0] disp_value,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_done
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             slot_end;
    logic             wrap;
    logic [3:0]       nib_p0;
    logic             blank_p0;
    logic [7:0]       seg_p0;
    logic [7:0]       sel_p0;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    function automatic logic digit_blank(input logic [31:0] val, input logic [2:0] d,
                                         input logic en);
        logic [31:0] upper;
        upper = val >> {d, 2'b00};
        return en && (d != 3'd0) && (upper == 32'd0);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_value <= 32'd0;
        end else if (wr_en && (wr_addr == DISP_ADDR)) begin
            disp_value <= wr_data;
        end
    end

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
        end
    end

    // Stage p0: decode the digit selected by the current idx and word.
    always_comb begin
        nib_p0   = disp_value[{idx, 2'b00} +: 4];
        blank_p0 = digit_blank(disp_value, idx, blank_en);
        seg_p0   = 8'hFF;
        sel_p0   = 8'hFF;
        if (!blank_p0) begin
            seg_p0 = seg_decode(nib_p0);
            sel_p0 = ~(8'b0000_0001 << idx);
        end
    end

    // Stage p1: registered pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_seg <= 8'hFF;
            o_sel <= 8'hFF;
        end else begin
            o_seg <= seg_p0;
            o_sel <= sel_p0;
        end
    end

endmodule
